// File: rtl/bloom_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bloom_scan_pkg
//  Brief    : Shared sizes, FSM encoding and result type for bloom_scan_ctrl.
//  Revision : 1.0
// ============================================================================
package bloom_scan_pkg;

   localparam int ARR_SIZE  = 288;
   localparam int P_SIZE    = 12;
   localparam int NOB       = 3;
   localparam int NOB_WIDTH = 2;
   localparam int NOP       = 24;
   localparam int NOP_WIDTH = 5;
   localparam int SETTLE    = 2;
   localparam int SETTLE_W  = $clog2(SETTLE + 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CLEAR     = 3'd1,
      ST_ISSUE     = 3'd2,
      ST_SETTLE    = 3'd3,
      ST_FLUSH     = 3'd4,
      ST_FLUSH_SET = 3'd5,
      ST_CAPTURE   = 3'd6,
      ST_RESP      = 3'd7
   } scan_state_t;

   typedef logic [NOP_WIDTH*NOP-1:0] tpn_arr_t;

   // A scan can be cancelled anywhere between accepting a job and presenting it.
   function automatic logic is_abortable(input scan_state_t s);
      return (s != ST_IDLE) && (s != ST_RESP);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Brief    : Two-request round-robin grant; pointer moves past the winner.
//  Revision : 1.0
// ============================================================================
module rr_arb2 (
   input  logic clk,
   input  logic rst_n,
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_accept,
   output logic o_grant
);

   logic r_ptr;

   // Favour the pointed-to requester, fall back to the other one.
   always_comb begin
      if (r_ptr) o_grant = i_req1 | ~i_req0;
      else       o_grant = ~i_req0 & i_req1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_ptr <= 1'b0;
      else if (i_accept) r_ptr <= ~o_grant;
   end

endmodule
`default_nettype wire

// File: rtl/bloom_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bloom_scan_ctrl
//  Brief    : Arbitrates two scan requesters and sequences find_bit_pattern.
//  Revision : 1.0
// ============================================================================
module bloom_scan_ctrl
   import bloom_scan_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       req0_valid,
   output logic                       req0_ready,
   input  logic [ARR_SIZE-1:0]        req0_arr,
   input  logic [4*P_SIZE-1:0]        req0_pat,
   input  logic                       req1_valid,
   output logic                       req1_ready,
   input  logic [ARR_SIZE-1:0]        req1_arr,
   input  logic [4*P_SIZE-1:0]        req1_pat,
   input  logic                       abort,
   output logic                       fbp_rst,
   output logic [NOB_WIDTH:0]         fbp_b_idx,
   output logic [ARR_SIZE-1:0]        fbp_a,
   output logic [P_SIZE-1:0]          fbp_x1,
   output logic [P_SIZE-1:0]          fbp_x2,
   output logic [P_SIZE-1:0]          fbp_x3,
   output logic [P_SIZE-1:0]          fbp_x4,
   output logic                       fbp_put_global,
   input  logic [NOP_WIDTH*NOP-1:0]   fbp_g_tpn_arr,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic                       rsp_id,
   output logic [NOP_WIDTH*NOP-1:0]   rsp_tpn_arr,
   output logic                       busy
);

   localparam logic [NOB_WIDTH:0]  c_nob_idx     = (NOB_WIDTH+1)'(NOB);
   localparam logic [SETTLE_W-1:0] c_settle_last = SETTLE_W'(SETTLE - 1);

   scan_state_t          r_state;
   logic [NOB_WIDTH:0]   r_blk;
   logic [SETTLE_W-1:0]  r_cnt;
   logic                 r_fbp_rst;
   tpn_arr_t             r_tpn;

   logic                 w_grant;
   logic                 w_accept;
   logic                 w_abort_scan;
   logic                 w_settle_done;
   logic [NOB_WIDTH:0]   w_blk_next;
   logic [4*P_SIZE-1:0]  w_pat;

   rr_arb2 u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_req0   (req0_valid),
      .i_req1   (req1_valid),
      .i_accept (w_accept),
      .o_grant  (w_grant)
   );

   // rst_n gates acceptance so ready stays low while reset is held.
   assign w_accept      = rst_n & (r_state == ST_IDLE) & (req0_valid | req1_valid) & ~abort;
   assign req0_ready    = w_accept & ~w_grant;
   assign req1_ready    = w_accept &  w_grant;
   assign w_abort_scan  = abort & is_abortable(r_state);
   assign w_settle_done = (r_cnt == c_settle_last);
   assign w_blk_next    = r_blk + 1'b1;
   assign w_pat         = w_grant ? req1_pat : req0_pat;

   assign fbp_rst        = r_fbp_rst;
   assign fbp_b_idx      = r_blk;
   assign fbp_put_global = ((r_state == ST_ISSUE) | (r_state == ST_FLUSH)) & ~abort;
   assign rsp_valid      = (r_state == ST_RESP);
   assign rsp_tpn_arr    = r_tpn;
   assign busy           = (r_state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_blk     <= '0;
         r_cnt     <= '0;
         r_fbp_rst <= 1'b0;
         r_tpn     <= '0;
         rsp_id    <= 1'b0;
         fbp_a     <= '0;
         fbp_x1    <= '0;
         fbp_x2    <= '0;
         fbp_x3    <= '0;
         fbp_x4    <= '0;
      end else begin
         r_fbp_rst <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  fbp_a     <= w_grant ? req1_arr : req0_arr;
                  fbp_x1    <= w_pat[0*P_SIZE +: P_SIZE];
                  fbp_x2    <= w_pat[1*P_SIZE +: P_SIZE];
                  fbp_x3    <= w_pat[2*P_SIZE +: P_SIZE];
                  fbp_x4    <= w_pat[3*P_SIZE +: P_SIZE];
                  rsp_id    <= w_grant;
                  r_blk     <= '0;
                  r_fbp_rst <= 1'b0;
                  r_state   <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               r_blk   <= '0;
               r_state <= ST_ISSUE;
            end
            ST_ISSUE: begin
               r_cnt   <= '0;
               r_state <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (w_settle_done) begin
                  r_cnt   <= '0;
                  r_blk   <= w_blk_next;
                  r_state <= (w_blk_next == c_nob_idx) ? ST_FLUSH : ST_ISSUE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_FLUSH: begin
               r_cnt   <= '0;
               r_state <= ST_FLUSH_SET;
            end
            ST_FLUSH_SET: begin
               if (w_settle_done) begin
                  r_cnt   <= '0;
                  r_state <= ST_CAPTURE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_CAPTURE: begin
               r_tpn   <= fbp_g_tpn_arr;
               r_state <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
         if (w_abort_scan) r_state <= ST_IDLE;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bloom_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bloom_scan_ctrl
//  Brief    : Scoreboard bench for bloom_scan_ctrl with a find_bit_pattern model.
//  Revision : 1.0
// ============================================================================
module tb_bloom_scan_ctrl;
   import bloom_scan_pkg::*;

   logic                      clk;
   logic                      rst_n;
   logic                      req0_valid, req0_ready, req1_valid, req1_ready;
   logic [ARR_SIZE-1:0]       req0_arr, req1_arr;
   logic [4*P_SIZE-1:0]       req0_pat, req1_pat;
   logic                      abort;
   logic                      fbp_rst;
   logic [NOB_WIDTH:0]        fbp_b_idx;
   logic [ARR_SIZE-1:0]       fbp_a;
   logic [P_SIZE-1:0]         fbp_x1, fbp_x2, fbp_x3, fbp_x4;
   logic                      fbp_put_global;
   logic [NOP_WIDTH*NOP-1:0]  fbp_g_tpn_arr;
   logic                      rsp_valid, rsp_ready, rsp_id, busy;
   logic [NOP_WIDTH*NOP-1:0]  rsp_tpn_arr;

   bloom_scan_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_arr(req0_arr), .req0_pat(req0_pat),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_arr(req1_arr), .req1_pat(req1_pat),
      .abort(abort), .fbp_rst(fbp_rst), .fbp_b_idx(fbp_b_idx), .fbp_a(fbp_a),
      .fbp_x1(fbp_x1), .fbp_x2(fbp_x2), .fbp_x3(fbp_x3), .fbp_x4(fbp_x4),
      .fbp_put_global(fbp_put_global), .fbp_g_tpn_arr(fbp_g_tpn_arr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_tpn_arr(rsp_tpn_arr), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Datapath stand-in: lists matching page numbers in order, published on the flush pulse.
   logic [119:0] dp_acc, dp_acc_n, dp_out;
   int           dp_cnt, dp_cnt_n;
   always_comb begin : dp_comb
      int         pg;
      logic [11:0] pv;
      pg       = 0;
      pv       = '0;
      dp_acc_n = dp_acc;
      dp_cnt_n = dp_cnt;
      if (fbp_put_global && fbp_b_idx < 3'd3) begin
         for (int p = 0; p < 8; p++) begin
            pg = int'(fbp_b_idx) * 8 + p;
            pv = fbp_a[pg*12 +: 12];
            if (pv == fbp_x1 || pv == fbp_x2 || pv == fbp_x3 || pv == fbp_x4) begin
               dp_acc_n[dp_cnt_n*5 +: 5] = 5'(pg);
               dp_cnt_n = dp_cnt_n + 1;
            end
         end
      end
   end
   always @(posedge clk) begin
      if (!fbp_rst) begin
         dp_acc <= '0;
         dp_cnt <= 0;
         dp_out <= '0;
      end else if (fbp_put_global) begin
         dp_acc <= dp_acc_n;
         dp_cnt <= dp_cnt_n;
         if (fbp_b_idx == 3'd3) dp_out <= dp_acc;
      end
   end
   assign fbp_g_tpn_arr = dp_out;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h want %0h at cycle %0d", name, got, exp, cyc);
      end
   endtask

   typedef struct {
      bit           id;
      logic [119:0] tpn;
      int           acc;
      int           pbase;
   } exp_t;
   exp_t sb[$];

   int         pulse_n = 0;
   logic [2:0] plog_b[128];
   int         plog_c[128];
   int         hs_cnt = 0;
   int         hs_cyc = 0;

   initial begin : monitor
      bit   seen;
      exp_t e;
      seen = 0;
      forever begin
         @(negedge clk);
         if (fbp_put_global && pulse_n < 128) begin
            plog_b[pulse_n] = fbp_b_idx;
            plog_c[pulse_n] = cyc;
            pulse_n++;
         end
         if (!rst_n) seen = 0;
         else if (rsp_valid && !seen) begin
            seen = 1;
            if (sb.size() == 0) check("rsp_unexpected", rsp_valid, 0);
            else begin
               e = sb.pop_front();
               check("rsp_id", rsp_id, e.id);
               check("rsp_tpn", rsp_tpn_arr, e.tpn);
               check("rsp_latency", cyc - e.acc, 15);
               check("put_count", pulse_n - e.pbase, 4);
               if (pulse_n - e.pbase == 4) begin
                  for (int i = 0; i < 4; i++) begin
                     check("put_b_idx", plog_b[e.pbase+i], i);
                     if (i > 0) check("put_gap", plog_c[e.pbase+i] - plog_c[e.pbase+i-1], 3);
                  end
               end
            end
         end
         if (rst_n && rsp_valid && rsp_ready) begin
            seen = 0;
            hs_cnt++;
            hs_cyc = cyc;
         end
      end
   end

   task automatic start_req(input bit id, input logic [287:0] arr, input logic [47:0] pat);
      if (id) begin req1_arr = arr; req1_pat = pat; req1_valid = 1'b1; end
      else    begin req0_arr = arr; req0_pat = pat; req0_valid = 1'b1; end
   endtask

   task automatic finish_req(input bit id, input bit expect_rsp, input logic [119:0] exp, output int acc_c);
      bit   got;
      exp_t e;
      got   = 0;
      acc_c = 0;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         if (id ? req1_ready : req0_ready) begin
            got   = 1;
            acc_c = cyc;
            check("other_ready", id ? req0_ready : req1_ready, 0);
            if (expect_rsp) begin
               e.id = id; e.tpn = exp; e.acc = cyc; e.pbase = pulse_n;
               sb.push_back(e);
            end
         end
      end
      if (!got) check("accept_timeout", got, 1);
      @(posedge clk); #1;
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
   endtask

   task automatic wait_hs(input int target);
      for (int k = 0; k < 200 && hs_cnt < target; k++) @(negedge clk);
      check("rsp_handshake_count", hs_cnt, target);
   endtask

   task automatic wait_pulses(input int n);
      int k;
      k = 0;
      for (int t = 0; t < 100 && k < n; t++) begin
         @(negedge clk);
         if (fbp_put_global) k++;
      end
      check("pulse_wait", k, n);
   endtask

   function automatic logic [119:0] pack(input int q[$]);
      logic [119:0] r;
      r = '0;
      foreach (q[i]) r[i*5 +: 5] = 5'(q[i]);
      return r;
   endfunction

   localparam logic [287:0] A1 = 288'h111_234_567_890_abc_222_333_012_123_234_111_345_444_678_abc_111_666_777_888_111_222_666_000_fff;
   localparam logic [287:0] A2 = 288'h111_222_222_333_111_222_333_111_123_234_111_345_444_678_abc_111_666_777_888_111_222_666_000_fff;
   localparam logic [47:0]  P1 = 48'h444_333_222_111;
   localparam logic [47:0]  P3 = 48'hfff_000_abc_777;

   initial begin : stim
      logic [119:0] e1, e2, e3;
      int           q[$];
      int           a0, a1;
      bit           seen_rsp;

      q = '{3, 4, 8, 11, 13, 17, 18, 23};                          e1 = pack(q);
      q = '{3, 4, 8, 11, 13, 16, 17, 18, 19, 20, 21, 22, 23};      e2 = pack(q);
      q = '{0, 1, 6, 9, 19};                                       e3 = pack(q);

      rst_n = 1'b0; abort = 1'b0; rsp_ready = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b0;
      req0_arr = A1; req0_pat = P1; req1_arr = '0; req1_pat = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_fbp_rst", fbp_rst, 0);
      check("reset_b_idx", fbp_b_idx, 0);
      check("reset_put", fbp_put_global, 0);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_ready0", req0_ready, 0);
      check("reset_fbp_a", fbp_a, 0);
      check("reset_rsp_tpn", rsp_tpn_arr, 0);
      req0_valid = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_fbp_rst", fbp_rst, 1);

      // abort in IDLE holds off acceptance, then the basic job
      abort = 1'b1;
      start_req(0, A1, P1);
      #1 check("abort_idle_ready0", req0_ready, 0);
      abort = 1'b0;
      #1 check("idle_ready0", req0_ready, 1);
      finish_req(0, 1, e1, a0);
      wait_hs(1);

      @(posedge clk); #1;
      start_req(0, A2, P1);
      finish_req(0, 1, e2, a0);
      wait_hs(2);

      // response held off: outputs stable, new requester waits
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      start_req(0, A1, P3);
      finish_req(0, 1, e3, a0);
      seen_rsp = 0;
      for (int k = 0; k < 40 && !seen_rsp; k++) begin
         @(negedge clk);
         seen_rsp = rsp_valid;
      end
      check("hold_rsp_seen", seen_rsp, 1);
      @(posedge clk); #1;
      start_req(1, A2, P1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("hold_valid", rsp_valid, 1);
         check("hold_id", rsp_id, 0);
         check("hold_tpn", rsp_tpn_arr, e3);
         check("hold_busy", busy, 1);
         check("hold_ready1", req1_ready, 0);
      end
      @(posedge clk); #1 rsp_ready = 1'b1;
      finish_req(1, 1, e2, a1);
      check("next_accept_gap", a1 - hs_cyc, 1);
      wait_hs(4);

      // abort in the SETTLE following the second put_global pulse
      @(posedge clk); #1;
      start_req(0, A1, P1);
      finish_req(0, 0, '0, a0);
      wait_pulses(2);
      @(posedge clk); #1 abort = 1'b1;
      check("abort_busy_before", busy, 1);
      @(posedge clk); #1 abort = 1'b0;
      check("abort_busy_after", busy, 0);
      check("abort_rsp_valid", rsp_valid, 0);
      seen_rsp = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (rsp_valid) seen_rsp = 1;
      end
      check("abort_no_rsp", seen_rsp, 0);
      @(posedge clk); #1;
      start_req(0, A2, P1);
      finish_req(0, 1, e2, a0);
      wait_hs(5);

      // rst_n dropped mid-SETTLE, then simultaneous requests from a reset pointer
      @(posedge clk); #1;
      start_req(0, A1, P1);
      finish_req(0, 0, '0, a0);
      wait_pulses(1);
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      check("midrst_fbp_rst", fbp_rst, 0);
      check("midrst_busy", busy, 0);
      check("midrst_b_idx", fbp_b_idx, 0);
      check("midrst_put", fbp_put_global, 0);
      check("midrst_fbp_a", fbp_a, 0);
      check("midrst_x1", fbp_x1, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      start_req(0, A1, P1);
      start_req(1, A1, P3);
      finish_req(0, 1, e1, a0);
      finish_req(1, 1, e3, a1);
      check("pair_accept_gap", a1 - hs_cyc, 1);
      wait_hs(7);

      repeat (5) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
      $fatal(1);
   end

endmodule
`default_nettype wire
